fft_frame_scheduler: RTL and testbench
======================================

Name: fft_frame_scheduler

Overview:
Streaming front-end controller for the FFT datapath. It accepts one complex sample per cycle under a valid/ready handshake and writes each sample into a ping-pong pair of N-point frame banks at bit-reversed addresses. It presents each completed frame, whole and in parallel, to the FFT stage under a second valid/ready handshake. Backpressure, frame alignment (start-of-frame), an optional natural-order bypass and status counters are handled here.

Parameters:
N, 8, FFT size in complex points; power of two, 4 to 64.
CNT_W, 16, width of the frames_out counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_sample  in  complex_t  input sample
in_sof  in  1  start-of-frame marker; qualified by in_valid && in_ready
bypass  in  1  1 = natural-order write (no bit reversal); sampled per frame
flush  in  1  synchronous pipeline clear
out_valid  out  1  complete frame available
out_ready  in  1  FFT stage consumes the frame
out_frame  out  complex_t [N-1:0]  frame in bit-reversed order (natural order if bypass)
frames_out  out  CNT_W  count of frames handed off; wraps
sof_err_cnt  out  8  count of premature in_sof events; saturates at 255

Behaviour:
- State: two banks (bank0, bank1) of N complex_t registers; bank_full[1:0]; wr_bank; rd_bank; wr_cnt[log2 N]; bank_bypass[1:0].
- Reset (reset==0 at clk edge):
  - All bank entries, bank_full, wr_bank, rd_bank, wr_cnt, bank_bypass, frames_out and sof_err_cnt go to 0.
  - Outputs after reset: out_valid=0, in_ready=1, out_frame all zero.
  - Reset dominates flush and all handshakes in the same cycle.
- in_ready = !bank_full[wr_bank]. This is combinational from registers only, with no path from in_valid.
- Accept (in_valid && in_ready):
  - Write address a = bypass_eff ? wr_cnt : bitrev(wr_cnt). Write bank[wr_bank][a] <= in_sample.
  - bypass_eff is the bypass input when wr_cnt==0; otherwise it is bank_bypass[wr_bank], latched at the index-0 accept.
  - wr_cnt increments.
- Frame complete (accept with wr_cnt==N-1): bank_full[wr_bank] <= 1, wr_bank flips, wr_cnt <= 0.
- in_sof on an accept with wr_cnt!=0:
  - The partial frame is abandoned. The sample is written as index 0 (address 0) of the same bank and wr_cnt <= 1.
  - bypass is re-latched, and sof_err_cnt increments (saturating).
- in_sof on an accept with wr_cnt==0 is normal. Missing in_sof at index 0 is not an error.
- Read side:
  - out_valid = bank_full[rd_bank]; out_frame = bank[rd_bank] contents.
  - Latency: the frame is visible the cycle after its last sample is accepted.
- Handoff (out_valid && out_ready): bank_full[rd_bank] <= 0, rd_bank flips, frames_out increments (wraps).
  - out_frame must stay stable while out_valid=1 and out_ready=0.
- Simultaneous frame completion and handoff:
  - These always target different banks; both updates take effect.
  - A bank released this cycle is writable next cycle, not this cycle.
- Both banks full: in_ready=0 and input stalls. No sample is ever dropped or overwritten.
- Throughput: 1 sample/cycle sustained when out_ready stays high; a frame drains every N cycles.
- flush=1:
  - Clears bank_full, wr_bank, rd_bank, wr_cnt and bank_bypass. Bank data and counters are kept.
  - Accept and handoff are ignored that cycle; out_valid=0 from the next cycle.
- Reset mid-frame: the partial frame is discarded with no residue; the next accepted sample is index 0.

Decomposition:
- Shared FFT package holds complex_t, a bitrev(idx, log2N) function and a localparam LOGN = $clog2(N).
- One natural sub-module: fft_frame_bank, an N-entry complex_t register array with a single write port (we, addr, data), synchronous clear, and full parallel read. It is instantiated twice.
- The controller holds the counters and the full/bank pointers.

Test Plan:
- Basic frame, N=8, bypass=0:
  - Stimulus: samples k=0..7 with re=k, im=-k, in_sof on k=0, out_ready=1.
  - Required: out_valid the cycle after k=7; out_frame = {re} 0,4,2,6,1,5,3,7; frames_out=1.
- Bypass: same stimulus with bypass=1 at k=0 (toggled to 0 mid-frame) -> out_frame re = 0..7 in natural order.
- Backpressure:
  - Stimulus: out_ready=0, stream 24 samples.
  - Required: in_ready drops after the 16th accept; samples 17-24 are held. Raising out_ready releases frame 1 (re 0..7), then frame 2 (re 8..15); frame 3 then fills; no loss.
- Premature SOF:
  - Stimulus: 3 samples, then in_sof with re=100 followed by 7 more samples.
  - Required: sof_err_cnt=1; the frame has out_frame[0].re=100 and contains none of the first 3 samples.
- Concurrency: continuous 64-sample stream with out_ready=1 -> in_ready never deasserts after the first frame; 8 frames; frames_out=8; every frame correct.
- Reset/flush:
  - Stimulus: reset=0 or flush=1 asserted at sample 5 with both banks partially/fully loaded.
  - Required: out_valid=0 next cycle; the next 8 samples form a clean frame. Under reset, out_frame reads zero until then.

Source files
------------

// File: rtl/fft_frame_scheduler_pkg.sv
// Shared FFT types and helpers: complex sample type, bit-reversal function.
package fft_frame_scheduler_pkg;

   localparam int unsigned CPLX_W = 16;
   localparam int unsigned FFT_N  = 8;
   localparam int unsigned LOGN   = $clog2(FFT_N);
   // Widest index supported (N up to 64)
   localparam int unsigned IDX_W  = 6;

   typedef struct packed {
      logic signed [CPLX_W-1:0] re;
      logic signed [CPLX_W-1:0] im;
   } complex_t;

   // Reverse the low 'logn' bits of idx; upper bits come back as zero.
   function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx,
                                                input int unsigned       logn);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < IDX_W; i++) begin
         if (i < logn) r[i] = idx[3'(logn - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// N-entry complex sample register bank: one write port, full parallel read.
module fft_frame_bank
   import fft_frame_scheduler_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [$clog2(N)-1:0] addr,
   input  complex_t             data,
   output complex_t [N-1:0]     frame
);

   complex_t [N-1:0] mem;

   // Storage: cleared by reset, otherwise single-entry write
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem <= '0;
      end else if (we) begin
         mem[addr] <= data;
      end
   end

   assign frame = mem;

endmodule

// File: rtl/fft_frame_scheduler.sv
// Streaming FFT front end: bit-reversed ping-pong frame assembly and
// whole-frame handoff to the FFT stage.
module fft_frame_scheduler
   import fft_frame_scheduler_pkg::*;
#(
   parameter int unsigned N     = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  complex_t         in_sample,
   input  logic             in_sof,
   input  logic             bypass,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output complex_t [N-1:0] out_frame,
   output logic [CNT_W-1:0] frames_out,
   output logic [7:0]       sof_err_cnt
);

   localparam int unsigned     AW       = $clog2(N);
   localparam logic [AW-1:0]   LAST_IDX = AW'(N - 1);

   logic [1:0]       bank_full;
   logic [1:0]       bank_full_next;
   logic [1:0]       bank_bypass;
   logic             wr_bank;
   logic             rd_bank;
   logic [AW-1:0]    wr_cnt;

   logic             accept;
   logic             handoff;
   logic             sof_restart;
   logic             at_index0;
   logic             bypass_eff;
   logic             frame_done;
   logic [AW-1:0]    wr_addr;
   logic [1:0]       bank_we;
   complex_t [N-1:0] frame0;
   complex_t [N-1:0] frame1;

   // Handshake qualification and write-address generation
   always_comb begin
      in_ready    = !bank_full[wr_bank];
      out_valid   = bank_full[rd_bank];
      accept      = in_valid && in_ready && !flush;
      handoff     = out_valid && out_ready && !flush;
      sof_restart = accept && in_sof && (wr_cnt != '0);
      // A premature SOF restarts the frame, so it is treated as index 0
      at_index0   = (wr_cnt == '0) || sof_restart;
      bypass_eff  = at_index0 ? bypass : bank_bypass[wr_bank];
      if (sof_restart) begin
         wr_addr = '0;
      end else if (bypass_eff) begin
         wr_addr = wr_cnt;
      end else begin
         wr_addr = AW'(bitrev(IDX_W'(wr_cnt), AW));
      end
      frame_done = accept && !sof_restart && (wr_cnt == LAST_IDX);
      bank_we[0] = accept && !wr_bank;
      bank_we[1] = accept &&  wr_bank;
   end

   // Next full flags: completion and handoff always hit different banks
   always_comb begin
      bank_full_next = bank_full;
      if (frame_done) bank_full_next[wr_bank] = 1'b1;
      if (handoff)    bank_full_next[rd_bank] = 1'b0;
   end

   // Bank pointers, fill flags and write counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         bank_full   <= '0;
         bank_bypass <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_cnt      <= '0;
      end else if (flush) begin
         bank_full   <= '0;
         bank_bypass <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_cnt      <= '0;
      end else begin
         bank_full <= bank_full_next;
         if (accept) begin
            if (at_index0) bank_bypass[wr_bank] <= bypass;
            if (frame_done) begin
               wr_cnt  <= '0;
               wr_bank <= !wr_bank;
            end else if (sof_restart) begin
               wr_cnt <= AW'(1);
            end else begin
               wr_cnt <= wr_cnt + AW'(1);
            end
         end
         if (handoff) rd_bank <= !rd_bank;
      end
   end

   // Status counters survive flush; only reset clears them
   always_ff @(posedge clk) begin
      if (!reset) begin
         frames_out  <= '0;
         sof_err_cnt <= '0;
      end else begin
         if (handoff) frames_out <= frames_out + CNT_W'(1);
         if (sof_restart && (sof_err_cnt != 8'hFF)) sof_err_cnt <= sof_err_cnt + 8'd1;
      end
   end

   fft_frame_bank #(.N(N)) u_bank0 (
      .clk   (clk),
      .reset (reset),
      .we    (bank_we[0]),
      .addr  (wr_addr),
      .data  (in_sample),
      .frame (frame0)
   );

   fft_frame_bank #(.N(N)) u_bank1 (
      .clk   (clk),
      .reset (reset),
      .we    (bank_we[1]),
      .addr  (wr_addr),
      .data  (in_sample),
      .frame (frame1)
   );

   assign out_frame = rd_bank ? frame1 : frame0;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler against a frame-level queue model.
module tb_fft_frame_scheduler;
   import fft_frame_scheduler_pkg::*;

   localparam int N      = 8;
   localparam int LOGN_T = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   complex_t         in_sample = '0;
   logic             in_sof = 1'b0;
   logic             bypass = 1'b0;
   logic             flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   complex_t [N-1:0] out_frame;
   logic [15:0]      frames_out;
   logic [7:0]       sof_err_cnt;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: completed frames in handoff order plus the partial frame
   complex_t [N-1:0] pend[$];
   complex_t         part[N];
   int               pcnt = 0;
   logic             pbyp = 1'b0;
   logic [15:0]      m_frames = '0;
   int               m_sof = 0;
   logic             m_acc = 1'b0;

   always #5 clk = ~clk;

   fft_frame_scheduler #(.N(N), .CNT_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sample   (in_sample),
      .in_sof      (in_sof),
      .bypass      (bypass),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_frame   (out_frame),
      .frames_out  (frames_out),
      .sof_err_cnt (sof_err_cnt)
   );

   function automatic int rev_idx(input int k);
      int r = 0;
      int v = k;
      for (int b = 0; b < LOGN_T; b++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   function automatic complex_t mk(input int re, input int im);
      complex_t c;
      c.re = 16'(re);
      c.im = 16'(im);
      return c;
   endfunction

   // Apply one cycle of inputs, advance the model across the same edge
   task automatic drive(input logic v, input logic sof, input logic byp, input complex_t s,
                        input logic ordy, input logic fl, input logic rst);
      logic acc;
      logic ho;
      complex_t [N-1:0] f;
      in_valid = v; in_sof = sof; bypass = byp; in_sample = s;
      out_ready = ordy; flush = fl; reset = rst;
      acc = v && (pend.size() < 2);
      ho  = ordy && (pend.size() > 0);
      m_acc = 1'b0;
      if (!rst) begin
         pend.delete(); pcnt = 0; pbyp = 1'b0; m_frames = '0; m_sof = 0;
      end else if (fl) begin
         pend.delete(); pcnt = 0; pbyp = 1'b0;
      end else begin
         if (ho) begin
            void'(pend.pop_front());
            m_frames = m_frames + 16'd1;
         end
         if (acc) begin
            m_acc = 1'b1;
            if (sof && pcnt != 0) begin
               m_sof = (m_sof < 255) ? m_sof + 1 : 255;
               part[0] = s; pcnt = 1; pbyp = byp;
            end else begin
               if (pcnt == 0) pbyp = byp;
               part[pcnt] = s;
               pcnt++;
               if (pcnt == N) begin
                  f = '0;
                  for (int k = 0; k < N; k++) f[pbyp ? k : rev_idx(k)] = part[k];
                  pend.push_back(f);
                  pcnt = 0;
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 1'b0, mk(77, 77), 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      compared++;
      if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      compared++;
      if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      compared++;
      if (out_frame !== '0) begin mismatched++; $display("FAIL reset_out_frame: got %h want 0", out_frame); end
      compared++;
      if (frames_out !== 16'd0) begin mismatched++; $display("FAIL reset_frames_out: got %0d want 0", frames_out); end
      compared++;
      if (sof_err_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_sof_err: got %0d want 0", sof_err_cnt); end
   endtask

   task automatic test_basic_frame();
      int exp_re[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < N; k++) begin
         compared++;
         if (in_ready !== 1'b1) begin mismatched++; $display("FAIL basic_in_ready k=%0d: got %b want 1", k, in_ready); end
         drive(1'b1, k == 0, 1'b0, mk(k, -k), 1'b1, 1'b0, 1'b1);
         if (k == N - 2) begin
            compared++;
            if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
         end
      end
      compared++;
      if (out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
      for (int i = 0; i < N; i++) begin
         compared++;
         if (out_frame[i].re !== 16'(exp_re[i]) || out_frame[i].im !== 16'(-exp_re[i])) begin
            mismatched++;
            $display("FAIL basic_slot[%0d]: got re=%0d im=%0d want re=%0d im=%0d",
                     i, out_frame[i].re, out_frame[i].im, exp_re[i], -exp_re[i]);
         end
      end
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      compared++;
      if (frames_out !== 16'd1) begin mismatched++; $display("FAIL basic_frames_out: got %0d want 1", frames_out); end
      compared++;
      if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_bypass();
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < N; k++) drive(1'b1, k == 0, k == 0, mk(k, 3 * k), 1'b0, 1'b0, 1'b1);
      compared++;
      if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bypass_out_valid: got %b want 1", out_valid); end
      for (int i = 0; i < N; i++) begin
         compared++;
         if (out_frame[i].re !== 16'(i)) begin
            mismatched++; $display("FAIL bypass_slot[%0d]: got %0d want %0d", i, out_frame[i].re, i);
         end
      end
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      int seq = 0;
      int iter = 0;
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 30; c++) begin
         compared++;
         if (in_ready !== (pend.size() < 2)) begin
            mismatched++; $display("FAIL bp_in_ready c=%0d: got %b want %b", c, in_ready, pend.size() < 2);
         end
         drive(1'b1, (seq % N) == 0, 1'b0, mk(seq, seq + 1000), 1'b0, 1'b0, 1'b1);
         if (m_acc) seq++;
      end
      compared++;
      if (seq !== 16) begin mismatched++; $display("FAIL bp_accept_count: got %0d want 16", seq); end
      compared++;
      if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_stalled: got %b want 0", in_ready); end
      for (int k = 0; k < N; k++) begin
         compared++;
         if (out_frame[rev_idx(k)].re !== 16'(k)) begin
            mismatched++; $display("FAIL bp_frame1 k=%0d: got %0d want %0d", k, out_frame[rev_idx(k)].re, k);
         end
      end
      drive(1'b1, (seq % N) == 0, 1'b0, mk(seq, seq + 1000), 1'b1, 1'b0, 1'b1);
      if (m_acc) seq++;
      for (int k = 0; k < N; k++) begin
         compared++;
         if (out_frame[rev_idx(k)].re !== 16'(N + k)) begin
            mismatched++; $display("FAIL bp_frame2 k=%0d: got %0d want %0d", k, out_frame[rev_idx(k)].re, N + k);
         end
      end
      while (iter < 40 && !(seq == 24 && pend.size() == 0)) begin
         compared++;
         if (in_ready !== (pend.size() < 2) || out_valid !== (pend.size() > 0)) begin
            mismatched++;
            $display("FAIL bp_handshake it=%0d: got rdy=%b vld=%b want rdy=%b vld=%b",
                     iter, in_ready, out_valid, pend.size() < 2, pend.size() > 0);
         end
         if (pend.size() > 0) begin
            compared++;
            if (out_frame !== pend[0]) begin
               mismatched++; $display("FAIL bp_frame it=%0d: got %h want %h", iter, out_frame, pend[0]);
            end
         end
         drive(seq < 24, (seq % N) == 0, 1'b0, mk(seq, seq + 1000), 1'b1, 1'b0, 1'b1);
         if (m_acc) seq++;
         iter++;
      end
      compared++;
      if (seq !== 24 || pend.size() != 0) begin
         mismatched++; $display("FAIL bp_timeout: got seq=%0d pend=%0d want 24/0", seq, pend.size());
      end
      compared++;
      if (frames_out !== 16'd3) begin mismatched++; $display("FAIL bp_frames_out: got %0d want 3", frames_out); end
   endtask

   task automatic test_premature_sof();
      logic stale;
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) drive(1'b1, k == 1, 1'b0, mk(k, k), 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, mk(100, 5), 1'b0, 1'b0, 1'b1);
      for (int k = 1; k < N; k++) drive(1'b1, 1'b0, 1'b0, mk(100 + k, 5), 1'b0, 1'b0, 1'b1);
      compared++;
      if (sof_err_cnt !== 8'd1) begin mismatched++; $display("FAIL psof_err_cnt: got %0d want 1", sof_err_cnt); end
      compared++;
      if (out_valid !== 1'b1) begin mismatched++; $display("FAIL psof_out_valid: got %b want 1", out_valid); end
      compared++;
      if (out_frame[0].re !== 16'sd100) begin mismatched++; $display("FAIL psof_slot0: got %0d want 100", out_frame[0].re); end
      stale = 1'b0;
      for (int i = 0; i < N; i++) if (out_frame[i].re >= 1 && out_frame[i].re <= 3) stale = 1'b1;
      compared++;
      if (stale !== 1'b0) begin mismatched++; $display("FAIL psof_stale_samples: got %b want 0", stale); end
      compared++;
      if (pend.size() == 0 || out_frame !== pend[0]) begin
         mismatched++; $display("FAIL psof_frame: got %h want model frame", out_frame);
      end
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      int seq = 0;
      logic [15:0] fo0;
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      fo0 = frames_out;
      while (seq < 64) begin
         compared++;
         if (in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_in_ready seq=%0d: got %b want 1", seq, in_ready); end
         compared++;
         if (out_valid !== (pend.size() > 0)) begin
            mismatched++; $display("FAIL b2b_out_valid seq=%0d: got %b want %b", seq, out_valid, pend.size() > 0);
         end
         if (pend.size() > 0) begin
            compared++;
            if (out_frame !== pend[0]) begin
               mismatched++; $display("FAIL b2b_frame seq=%0d: got %h want %h", seq, out_frame, pend[0]);
            end
         end
         drive(1'b1, (seq % N) == 0, 1'($urandom_range(0, 1)),
               mk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535))), 1'b1, 1'b0, 1'b1);
         if (m_acc) seq++;
         else break;
      end
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      compared++;
      if (frames_out !== fo0 + 16'd8) begin
         mismatched++; $display("FAIL b2b_frames_out: got %0d want %0d", frames_out, fo0 + 16'd8);
      end
   endtask

   // use_reset=0 exercises flush, 1 exercises a mid-frame reset
   task automatic test_flush_reset(input logic use_reset);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < N; k++) drive(1'b1, k == 0, 1'b0, mk(k, 0), 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) drive(1'b1, k == 0 || k == 2, 1'b0, mk(20 + k, 0), 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, mk(999, 999), 1'b1, !use_reset, use_reset ? 1'b0 : 1'b1);
      compared++;
      if (out_valid !== 1'b0) begin mismatched++; $display("FAIL clr%0d_out_valid: got %b want 0", use_reset, out_valid); end
      compared++;
      if (in_ready !== 1'b1) begin mismatched++; $display("FAIL clr%0d_in_ready: got %b want 1", use_reset, in_ready); end
      compared++;
      if (frames_out !== m_frames || sof_err_cnt !== 8'(m_sof)) begin
         mismatched++;
         $display("FAIL clr%0d_counters: got fo=%0d se=%0d want fo=%0d se=%0d",
                  use_reset, frames_out, sof_err_cnt, m_frames, m_sof);
      end
      if (use_reset) begin
         compared++;
         if (out_frame !== '0) begin mismatched++; $display("FAIL clr1_out_frame: got %h want 0", out_frame); end
      end
      for (int k = 0; k < N; k++) drive(1'b1, k == 0, 1'b0, mk(50 + k, 0), 1'b0, 1'b0, 1'b1);
      compared++;
      if (out_valid !== 1'b1) begin mismatched++; $display("FAIL clr%0d_new_valid: got %b want 1", use_reset, out_valid); end
      for (int k = 0; k < N; k++) begin
         compared++;
         if (out_frame[rev_idx(k)].re !== 16'(50 + k)) begin
            mismatched++;
            $display("FAIL clr%0d_new_frame k=%0d: got %0d want %0d", use_reset, k, out_frame[rev_idx(k)].re, 50 + k);
         end
      end
   endtask

   task automatic test_sof_saturation();
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 300; c++) drive(1'b1, 1'b1, 1'b0, mk(c, c), 1'b1, 1'b0, 1'b1);
      compared++;
      if (sof_err_cnt !== 8'd255) begin mismatched++; $display("FAIL sat_sof_err: got %0d want 255", sof_err_cnt); end
      compared++;
      if (out_valid !== 1'b0 || frames_out !== 16'd0) begin
         mismatched++; $display("FAIL sat_no_frames: got vld=%b fo=%0d want 0/0", out_valid, frames_out);
      end
   endtask

   task automatic test_random();
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 800; c++) begin
         compared++;
         if (in_ready !== (pend.size() < 2)) begin
            mismatched++; $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, in_ready, pend.size() < 2);
         end
         compared++;
         if (out_valid !== (pend.size() > 0)) begin
            mismatched++; $display("FAIL rnd_out_valid c=%0d: got %b want %b", c, out_valid, pend.size() > 0);
         end
         compared++;
         if (frames_out !== m_frames || sof_err_cnt !== 8'(m_sof)) begin
            mismatched++;
            $display("FAIL rnd_counters c=%0d: got fo=%0d se=%0d want fo=%0d se=%0d",
                     c, frames_out, sof_err_cnt, m_frames, m_sof);
         end
         if (pend.size() > 0) begin
            compared++;
            if (out_frame !== pend[0]) begin
               mismatched++; $display("FAIL rnd_frame c=%0d: got %h want %h", c, out_frame, pend[0]);
            end
         end
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
               mk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535))),
               $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 127) != 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_frame();
      test_bypass();
      test_backpressure();
      test_premature_sof();
      test_back_to_back();
      test_flush_reset(1'b0);
      test_flush_reset(1'b1);
      test_sof_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
